// File: rtl/load_store_unit.sv
// load_store_unit
//   Sequences CPU load/store requests onto a single-ported data memory.
//   Aligned accesses take one memory beat. Misaligned half/word accesses
//   are either split into byte beats (SPLIT_EN=1) or rejected with
//   resp_err (SPLIT_EN=0). Every accepted request ends with a one-cycle
//   resp_valid pulse.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_we/op/ext         store flag, access size, load sign-extension
//   req_addr/req_wdata    byte address, store data (low bytes used)
//   mem_wr/op/ext         data-memory write enable, size, extension
//   mem_addr/mem_wdata    data-memory byte address and write data
//   mem_rdata             data-memory combinational read data
//   resp_valid            completion pulse
//   resp_rdata/resp_err   load result / error flag, zero unless resp_valid
//   mis_cnt               completed split accesses, saturating

module load_store_unit #(
    parameter int unsigned SPLIT_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_op,
    input  logic        req_ext,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_wr,
    output logic [1:0]  mem_op,
    output logic        mem_ext,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [15:0] mis_cnt
);

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;
    localparam logic [1:0] MEM_ILL  = 2'b11;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BEAT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic SPLIT = (SPLIT_EN != 0);

    logic [1:0]  state;
    logic        cap_we;
    logic [1:0]  cap_op;
    logic        cap_ext;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        split;
    logic [1:0]  beat;
    logic [1:0]  last_beat;
    logic [31:0] result;
    logic        err;

    logic        req_mis;
    logic        req_bad;
    logic [1:0]  req_last;
    logic [7:0]  beat_byte;
    logic [31:0] next_result;

    // Request classification, evaluated on the raw request inputs.
    always_comb begin
        req_mis  = ((req_op == MEM_HALF) && req_addr[0]) ||
                   ((req_op == MEM_WORD) && (req_addr[1:0] != 2'b00));
        req_bad  = (req_op == MEM_ILL) || (req_mis && !SPLIT);
        req_last = 2'd0;
        if (req_mis && !req_bad) begin
            req_last = (req_op == MEM_HALF) ? 2'd1 : 2'd3;
        end
    end

    // Store byte carried by the current split beat.
    always_comb begin
        beat_byte = cap_wdata[7:0];
        case (beat)
            2'd1:    beat_byte = cap_wdata[15:8];
            2'd2:    beat_byte = cap_wdata[23:16];
            2'd3:    beat_byte = cap_wdata[31:24];
            default: beat_byte = cap_wdata[7:0];
        endcase
    end

    // Load result after sampling the current beat. Split loads assemble
    // bytes into the already-cleared result; a split signed half is
    // extended on its final beat once bit 15 is known.
    always_comb begin
        next_result = result;
        if (!split) begin
            next_result = mem_rdata;
        end else begin
            case (beat)
                2'd1:    next_result[15:8]  = mem_rdata[7:0];
                2'd2:    next_result[23:16] = mem_rdata[7:0];
                2'd3:    next_result[31:24] = mem_rdata[7:0];
                default: next_result[7:0]   = mem_rdata[7:0];
            endcase
            if ((beat == last_beat) && (cap_op == MEM_HALF) && cap_ext) begin
                next_result[31:16] = {16{next_result[15]}};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cap_we    <= 1'b0;
            cap_op    <= MEM_WORD;
            cap_ext   <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            split     <= 1'b0;
            beat      <= 2'd0;
            last_beat <= 2'd0;
            result    <= '0;
            err       <= 1'b0;
            mis_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_we    <= req_we;
                        cap_op    <= req_op;
                        cap_ext   <= req_ext;
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
                        split     <= req_mis && !req_bad;
                        beat      <= 2'd0;
                        last_beat <= req_last;
                        result    <= '0;
                        err       <= req_bad;
                        state     <= req_bad ? RESP : BEAT;
                    end
                end
                BEAT: begin
                    if (!cap_we) begin
                        result <= next_result;
                    end
                    if (beat == last_beat) begin
                        state <= RESP;
                        if (split && (mis_cnt != '1)) begin
                            mis_cnt <= mis_cnt + 16'd1;
                        end
                    end else begin
                        beat <= beat + 2'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        resp_rdata = resp_valid ? result : '0;
        resp_err   = resp_valid & err;
    end

    // Memory port is purely a function of state, so an asynchronous reset
    // removes any in-flight write immediately.
    always_comb begin
        mem_wr    = 1'b0;
        mem_op    = MEM_WORD;
        mem_ext   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == BEAT) begin
            mem_wr = cap_we;
            if (split) begin
                mem_op    = MEM_BYTE;
                mem_ext   = 1'b0;
                mem_addr  = cap_addr + {30'd0, beat};
                mem_wdata = {24'd0, beat_byte};
            end else begin
                mem_op    = cap_op;
                mem_ext   = cap_ext;
                mem_addr  = cap_addr;
                mem_wdata = cap_wdata;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Randomized scoreboard bench for load_store_unit. The driver pushes
//   expected memory beats and responses computed from a byte-array model;
//   a negedge monitor pops and compares whatever the DUT presents.
//   A second instance with SPLIT_EN=0 covers the reject path.

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_ext;
    logic [1:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic        mem_wr, mem_ext;
    logic [1:0]  mem_op;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [15:0] mis_cnt;

    // SPLIT_EN=0 instance
    logic        req_valid0, req_ready0, req_we0, req_ext0;
    logic [1:0]  req_op0;
    logic [31:0] req_addr0, req_wdata0;
    logic        mem_wr0, mem_ext0;
    logic [1:0]  mem_op0;
    logic [31:0] mem_addr0, mem_wdata0;
    logic [31:0] mem_rdata0 = 32'hCAFEF00D;
    logic        resp_valid0, resp_err0;
    logic [31:0] resp_rdata0;
    logic [15:0] mis_cnt0;

    always #5 clk = ~clk;

    load_store_unit #(.SPLIT_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_op(req_op), .req_ext(req_ext), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .mem_wr(mem_wr), .mem_op(mem_op), .mem_ext(mem_ext),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mis_cnt(mis_cnt)
    );

    load_store_unit #(.SPLIT_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
        .req_op(req_op0), .req_ext(req_ext0), .req_addr(req_addr0),
        .req_wdata(req_wdata0),
        .mem_wr(mem_wr0), .mem_op(mem_op0), .mem_ext(mem_ext0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0),
        .resp_valid(resp_valid0), .resp_rdata(resp_rdata0),
        .resp_err(resp_err0), .mis_cnt(mis_cnt0)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  op;
        logic        ext;
        logic [31:0] addr;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [15:0] mis;
        int unsigned n;
        int unsigned acc;
    } resp_t;

    beat_t       beat_q[$];
    resp_t       resp_q[$];
    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;
    logic [15:0] mis_model = '0;

    logic [7:0] sim_mem [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_byte(logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] rdb(bit use_ref, logic [31:0] a);
        if (use_ref) return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
        return sim_mem.exists(a) ? sim_mem[a] : init_byte(a);
    endfunction

    function automatic int size_of(logic [1:0] op);
        return (op == 2'd0) ? 1 : (op == 2'd1) ? 2 : 4;
    endfunction

    // Sized little-endian read with optional sign extension.
    function automatic logic [31:0] load(bit use_ref, logic [31:0] a,
                                         logic [1:0] op, logic ext);
        logic [31:0] v = '0;
        int n = size_of(op);
        for (int k = 0; k < n; k++) v[8*k +: 8] = rdb(use_ref, a + 32'(k));
        if (ext && n == 1) v[31:8]  = {24{v[7]}};
        if (ext && n == 2) v[31:16] = {16{v[15]}};
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Data memory seen by the DUT: outputs are stable by the negedge, so
    // writing and refreshing read data there behaves like a combinational
    // memory that commits at the following rising edge.
    always @(negedge clk) begin
        if (mem_wr) begin
            for (int k = 0; k < size_of(mem_op); k++)
                sim_mem[mem_addr + 32'(k)] = mem_wdata[8*k +: 8];
        end
        mem_rdata = load(0, mem_addr, mem_op, mem_ext);
    end

    // Monitor
    int unsigned beats_seen = 0;
    always @(negedge clk) begin
        beat_t b;
        resp_t r;
        if (!rst_n) begin
            beats_seen = 0;
        end else begin
            if (mem_wr || mem_op != 2'd2 || mem_ext || mem_addr != 0 || mem_wdata != 0) begin
                total++;
                if (beat_q.size() == 0) begin
                    bad++;
                    $display("FAIL beat unexpected got wr=%0b op=%0d addr=%h wdata=%h",
                             mem_wr, mem_op, mem_addr, mem_wdata);
                end else begin
                    b = beat_q.pop_front();
                    if (mem_wr !== b.wr || mem_op !== b.op || mem_ext !== b.ext ||
                        mem_addr !== b.addr || mem_wdata !== b.wdata) begin
                        bad++;
                        $display("FAIL beat got wr=%0b op=%0d ext=%0b addr=%h wdata=%h exp wr=%0b op=%0d ext=%0b addr=%h wdata=%h",
                                 mem_wr, mem_op, mem_ext, mem_addr, mem_wdata,
                                 b.wr, b.op, b.ext, b.addr, b.wdata);
                    end
                end
                beats_seen++;
            end
            total++;
            if (resp_valid) begin
                if (resp_q.size() == 0) begin
                    bad++;
                    $display("FAIL resp unexpected got rdata=%h err=%0b", resp_rdata, resp_err);
                end else begin
                    r = resp_q.pop_front();
                    if (resp_rdata !== r.rdata || resp_err !== r.err || mis_cnt !== r.mis ||
                        cyc != r.acc + r.n || beats_seen != r.n) begin
                        bad++;
                        $display("FAIL resp got rdata=%h err=%0b mis=%0d cyc=%0d beats=%0d exp rdata=%h err=%0b mis=%0d cyc=%0d beats=%0d",
                                 resp_rdata, resp_err, mis_cnt, cyc, beats_seen,
                                 r.rdata, r.err, r.mis, r.acc + r.n, r.n);
                    end
                end
                beats_seen = 0;
            end else if (resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
                bad++;
                $display("FAIL idle_resp got rdata=%h err=%0b exp rdata=0 err=0",
                         resp_rdata, resp_err);
            end
        end
    end

    // Reference model: what a correct unit does to a byte-addressed memory.
    task automatic model(logic we, logic [1:0] op, logic ext, logic [31:0] addr,
                         logic [31:0] wdata, int unsigned acc);
        resp_t r;
        beat_t b;
        int    n;
        logic  mis = (op == 2'd1 && addr[0]) || (op == 2'd2 && addr[1:0] != 2'd0);
        r.acc = acc; r.rdata = '0; r.err = 1'b0; r.n = 0;
        if (op == 2'd3) begin
            r.err = 1'b1;
        end else if (!mis) begin
            b = '{we, op, ext, addr, wdata};
            beat_q.push_back(b);
            r.n = 1;
            if (we) for (int k = 0; k < size_of(op); k++) ref_mem[addr + 32'(k)] = wdata[8*k +: 8];
            else r.rdata = load(1, addr, op, ext);
        end else begin
            n = size_of(op);
            for (int i = 0; i < n; i++) begin
                b = '{we, 2'd0, 1'b0, addr + 32'(i), {24'd0, wdata[8*i +: 8]}};
                beat_q.push_back(b);
                if (we) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
                else r.rdata[8*i +: 8] = rdb(1, addr + 32'(i));
            end
            if (!we && op == 2'd1 && ext) r.rdata[31:16] = {16{r.rdata[15]}};
            if (mis_model != 16'hFFFF) mis_model++;
            r.n = n;
        end
        r.mis = mis_model;
        resp_q.push_back(r);
    endtask

    task automatic wait_ready();
        int unsigned t = 0;
        @(negedge clk);
        while (!req_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) chk("ready_timeout", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic issue(logic we, logic [1:0] op, logic ext, logic [31:0] addr,
                         logic [31:0] wdata);
        wait_ready();
        req_we = we; req_op = op; req_ext = ext; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        model(we, op, ext, addr, wdata, cyc);
    endtask

    task automatic drain();
        int unsigned t = 0;
        while ((resp_q.size() != 0 || !req_ready) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_resp_q", resp_q.size(), 0);
        chk("drain_beat_q", beat_q.size(), 0);
    endtask

    task automatic poke(logic [31:0] a, logic [7:0] d);
        sim_mem[a] = d;
        ref_mem[a] = d;
    endtask

    task automatic issue0(logic we, logic [1:0] op, logic [31:0] addr, bit reject);
        @(negedge clk);
        chk("dut0_ready", {31'd0, req_ready0}, 32'd1);
        req_we0 = we; req_op0 = op; req_ext0 = 1'b0; req_addr0 = addr;
        req_wdata0 = 32'h55667788; req_valid0 = 1'b1;
        @(posedge clk);
        #1;
        req_valid0 = 1'b0;
        if (reject) begin
            chk("dut0_rej_valid", {31'd0, resp_valid0}, 32'd1);
            chk("dut0_rej_err", {31'd0, resp_err0}, 32'd1);
            chk("dut0_rej_rdata", resp_rdata0, 32'd0);
            chk("dut0_rej_nobeat", {mem_wr0, mem_op0, mem_addr0[28:0]}, {1'b0, 2'd2, 29'd0});
        end else begin
            chk("dut0_beat_valid", {31'd0, resp_valid0}, 32'd0);
            chk("dut0_beat_addr", mem_addr0, addr);
            chk("dut0_beat_op", {30'd0, mem_op0}, {30'd0, op});
            @(posedge clk);
            #1;
            chk("dut0_resp_valid", {31'd0, resp_valid0}, 32'd1);
            chk("dut0_resp_err", {31'd0, resp_err0}, 32'd0);
            chk("dut0_resp_rdata", resp_rdata0, we ? 32'd0 : 32'hCAFEF00D);
        end
        @(posedge clk);
        #1;
        chk("dut0_back_idle", {31'd0, resp_valid0}, 32'd0);
    endtask

    initial begin
        logic [1:0] op;
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_op = 2'd0; req_ext = 1'b0;
        req_addr = '0; req_wdata = '0;
        req_valid0 = 1'b0; req_we0 = 1'b0; req_op0 = 2'd0; req_ext0 = 1'b0;
        req_addr0 = '0; req_wdata0 = '0;

        #2;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_mis_cnt", {16'd0, mis_cnt}, 32'd0);
        chk("rst_mem_ctl", {29'd0, mem_wr, mem_op}, {29'd0, 1'b0, 2'd2});
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);

        poke(32'h2004, 8'hEF); poke(32'h2005, 8'hBE);
        poke(32'h2006, 8'hAD); poke(32'h2007, 8'hDE);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed cases
        issue(1'b0, 2'd2, 1'b0, 32'h0000_2004, 32'h0);
        issue(1'b1, 2'd2, 1'b0, 32'h0000_2001, 32'h1122_3344);
        drain();
        poke(32'h2003, 8'h80); poke(32'h2004, 8'hFF);
        issue(1'b0, 2'd1, 1'b1, 32'h0000_2003, 32'h0);
        issue(1'b0, 2'd3, 1'b0, 32'h0000_2010, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h0);
        issue(1'b1, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'h0000_9A7B);
        issue(1'b0, 2'd0, 1'b1, 32'hFFFF_FFFF, 32'h0);

        // Random traffic within a small window so loads hit earlier stores
        for (int i = 0; i < 200; i++) begin
            op = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            issue(1'($urandom_range(0, 1)), op, 1'($urandom_range(0, 1)),
                  32'h2000 + 32'($urandom_range(0, 63)), $urandom);
        end
        drain();

        // Reset during the second beat of a split store
        wait_ready();
        req_we = 1'b1; req_op = 2'd2; req_ext = 1'b0;
        req_addr = 32'h0000_2011; req_wdata = 32'hA1B2_C3D4; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        beat_q.push_back('{1'b1, 2'd0, 1'b0, 32'h0000_2011, 32'h0000_00D4});
        ref_mem[32'h2011] = 8'hD4;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("abort_mis_cnt", {16'd0, mis_cnt}, 32'd0);
        chk("abort_beat_q", beat_q.size(), 0);
        beat_q.delete();
        resp_q.delete();
        mis_model = '0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        issue(1'b0, 2'd2, 1'b0, 32'h0000_2010, 32'h0);
        issue(1'b0, 2'd1, 1'b0, 32'h0000_2013, 32'h0);
        drain();

        // Reject path with splitting disabled
        issue0(1'b0, 2'd1, 32'h0000_2003, 1'b1);
        issue0(1'b1, 2'd2, 32'h0000_2002, 1'b1);
        issue0(1'b0, 2'd3, 32'h0000_2000, 1'b1);
        issue0(1'b0, 2'd2, 32'h0000_2008, 1'b0);
        issue0(1'b1, 2'd1, 32'h0000_200A, 1'b0);
        chk("dut0_mis_cnt", {16'd0, mis_cnt0}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
